// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display checkers: pattern constants,
// segment bit positions, scan-reader FSM states and one-hot helpers.
package seg7_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    typedef enum int unsigned {
        SEG_A = 0, SEG_B = 1, SEG_C = 2, SEG_D = 3,
        SEG_E = 4, SEG_F = 5, SEG_G = 6
    } seg_index_t;

    // Active-high segment levels, bit order gfedcba.
    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;
    localparam logic [6:0] PAT_A = 7'h77;
    localparam logic [6:0] PAT_B = 7'h7C;
    localparam logic [6:0] PAT_C = 7'h39;
    localparam logic [6:0] PAT_D = 7'h5E;
    localparam logic [6:0] PAT_E = 7'h79;
    localparam logic [6:0] PAT_F = 7'h71;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } scan_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to hex value decoder; hit is low for any
// pattern that is not one of the sixteen hex glyphs.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] value
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        hit   = 1'b1;
        value = 4'h0;
        case (seg)
            PAT_0:   value = 4'h0;
            PAT_1:   value = 4'h1;
            PAT_2:   value = 4'h2;
            PAT_3:   value = 4'h3;
            PAT_4:   value = 4'h4;
            PAT_5:   value = 4'h5;
            PAT_6:   value = 4'h6;
            PAT_7:   value = 4'h7;
            PAT_8:   value = 4'h8;
            PAT_9:   value = 4'h9;
            PAT_A:   value = 4'hA;
            PAT_B:   value = 4'hB;
            PAT_C:   value = 4'hC;
            PAT_D:   value = 4'hD;
            PAT_E:   value = 4'hE;
            PAT_F:   value = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Observes a multiplexed 4-digit 7-segment bus and reconstructs the displayed
// hex digits once each digit's pattern has been stable for STABLE_CYCLES clocks.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  dig_sel,
    input  logic [6:0]  seg,
    output logic [15:0] hex_out,
    output logic [3:0]  digit_valid,
    output logic [3:0]  bad_pattern,
    output logic        frame_done
);

    localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);

    scan_state_t state, state_nxt;
    logic [3:0]  held_sel;
    logic [6:0]  held_seg;
    logic [7:0]  cnt;
    logic [3:0]  seen;

    logic        differ, load, count_up, capture;
    logic        dec_hit;
    logic [3:0]  dec_value;
    logic [1:0]  cap_idx;

    // Decoding the held copy keeps every output a pure register.
    seg7_pattern_decode u_decode (
        .seg   (held_seg),
        .hit   (dec_hit),
        .value (dec_value)
    );

    assign differ  = {dig_sel, seg} != {held_sel, held_seg};
    assign cap_idx = onehot_index4(held_sel);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        count_up  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE:  load = differ;
            ST_TRACK: begin
                if (differ) begin
                    load = 1'b1;
                end else begin
                    count_up = 1'b1;
                    if (cnt == CAP_AT) begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD:  load = differ;
            default:  state_nxt = ST_IDLE;
        endcase
        if (load) state_nxt = is_onehot4(dig_sel) ? ST_TRACK : ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            held_sel    <= '0;
            held_seg    <= '0;
            cnt         <= '0;
            seen        <= '0;
            hex_out     <= '0;
            digit_valid <= '0;
            bad_pattern <= '0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            if (load) begin
                held_sel <= dig_sel;
                held_seg <= seg;
                cnt      <= 8'd1;
            end else if (count_up && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
            if (capture) begin
                if (dec_hit) begin
                    hex_out[{cap_idx, 2'b00} +: 4] <= dec_value;
                    digit_valid[cap_idx]           <= 1'b1;
                    bad_pattern[cap_idx]           <= 1'b0;
                end else begin
                    digit_valid[cap_idx] <= 1'b0;
                    bad_pattern[cap_idx] <= 1'b1;
                end
                // A frame completes only when a capture fills the last unseen digit.
                if ((seen | held_sel) == 4'hF) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen | held_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized and directed bench for seg7_scan_reader, checked cycle by cycle
// against a run-length reference model of the display observer.
module tb_seg7_scan_reader;

    localparam int S = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  dig_sel;
    logic [6:0]  seg;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic [3:0]  bad_pattern;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the current input value and how many
    // consecutive edges it has been present.
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_hex;
    logic [3:0]  m_valid, m_bad, m_seen;
    logic        m_done;
    logic [6:0]  pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
        .clock       (clock),
        .reset       (reset),
        .dig_sel     (dig_sel),
        .seg         (seg),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .bad_pattern (bad_pattern),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] sel, input logic [6:0] sg);
        int  idx;
        int  val;
        if (rst) begin
            m_prev  = '0;
            m_run   = 0;
            m_hex   = '0;
            m_valid = '0;
            m_bad   = '0;
            m_seen  = '0;
            m_done  = 1'b0;
            return;
        end
        m_done = 1'b0;
        if ({sel, sg} == m_prev) begin
            m_run++;
        end else begin
            m_prev = {sel, sg};
            m_run  = 1;
        end
        if (m_run == S && $onehot(sel)) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            val = -1;
            for (int v = 0; v < 16; v++) if (pat_tab[v] == sg) val = v;
            if (val >= 0) begin
                m_hex[idx*4 +: 4] = 4'(val);
                m_valid[idx]      = 1'b1;
                m_bad[idx]        = 1'b0;
            end else begin
                m_valid[idx] = 1'b0;
                m_bad[idx]   = 1'b1;
            end
            if ((m_seen | sel) == 4'hF) begin
                m_seen = '0;
                m_done = 1'b1;
            end else begin
                m_seen = m_seen | sel;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] sel, input logic [6:0] sg);
        reset   = rst;
        dig_sel = sel;
        seg     = sg;
        @(posedge clock);
        model_edge(rst, sel, sg);
        @(negedge clock);
        check("hex_out",     32'(hex_out),     32'(m_hex));
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
        check("frame_done",  32'(frame_done),  32'(m_done));
    endtask

    initial begin
        logic [3:0] r_sel;
        logic [6:0] r_seg;
        int         frames;

        reset = 1'b1; dig_sel = '0; seg = '0;
        repeat (2) step(1'b1, 4'b0000, 7'h00);

        // Digit 0 shows "2": captured on the fourth edge, not before.
        repeat (3) step(1'b0, 4'b0001, 7'h5B);
        check("pre_capture_nibble0", 32'(hex_out[3:0]), 32'h0);
        step(1'b0, 4'b0001, 7'h5B);
        check("capture_nibble0", 32'(hex_out[3:0]), 32'h2);
        check("capture_valid0",  32'(digit_valid),  32'b0001);

        // Full scan of "F431" completes a frame.
        repeat (5) step(1'b0, 4'b0001, 7'h06);
        repeat (5) step(1'b0, 4'b0010, 7'h4F);
        repeat (5) step(1'b0, 4'b0100, 7'h66);
        repeat (3) step(1'b0, 4'b1000, 7'h71);
        step(1'b0, 4'b1000, 7'h71);
        check("frame_pulse", 32'(frame_done), 32'h1);
        check("frame_hex",   32'(hex_out),    32'hF431);
        step(1'b0, 4'b1000, 7'h71);
        check("frame_pulse_end", 32'(frame_done), 32'h0);

        // Toggling pattern never settles long enough.
        for (int k = 0; k < 6; k++) begin
            repeat (2) step(1'b0, 4'b0010, 7'h3F);
            repeat (2) step(1'b0, 4'b0010, 7'h06);
        end
        check("toggle_nibble1", 32'(hex_out[7:4]), 32'h3);

        // Unrecognised pattern on digit 2.
        repeat (6) step(1'b0, 4'b0100, 7'h01);
        check("bad_flag2",   32'(bad_pattern),   32'b0100);
        check("bad_nibble2", 32'(hex_out[11:8]), 32'h4);

        // Ineligible selects.
        frames = 0;
        repeat (10) begin step(1'b0, 4'b0011, 7'h3F); frames += int'(frame_done); end
        repeat (10) begin step(1'b0, 4'b0000, 7'h3F); frames += int'(frame_done); end
        check("ineligible_frames", 32'(frames), 32'h0);

        // Reset inside a window restarts it; capture four edges after release.
        repeat (2) step(1'b0, 4'b1000, 7'h7F);
        step(1'b1, 4'b1000, 7'h7F);
        repeat (3) step(1'b0, 4'b1000, 7'h7F);
        check("post_reset_early", 32'(digit_valid), 32'h0);
        step(1'b0, 4'b1000, 7'h7F);
        check("post_reset_capture", 32'(hex_out), 32'h8000);

        // Random scanning with glitches, bad patterns, odd selects and resets.
        r_sel = 4'b0001; r_seg = 7'h3F;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(1, 2)) step(1'b1, r_sel, r_seg);
                continue;
            end
            case ($urandom_range(0, 9))
                7:       r_sel = 4'b0000;
                8, 9:    r_sel = 4'($urandom_range(0, 15));
                default: r_sel = 4'(1 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 3) == 0) r_seg = 7'($urandom_range(0, 127));
            else                           r_seg = pat_tab[$urandom_range(0, 15)];
            repeat ($urandom_range(1, 7)) step(1'b0, r_sel, r_seg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the hex-to-7-segment decoders: watches a time-multiplexed 4-digit 7-segment display bus (one-hot digit select plus segment lines) and reconstructs the four displayed hex digits. Used as an observer/loopback checker behind the display driver path, so lab circuits can be self-checked on the board. Each digit is captured only after its pattern has been stable for a programmable number of clocks; unrecognised patterns are flagged per digit.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before capture; legal range 2..255.
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- dig_sel  in  4  digit enable, bit i selects digit i; only exactly-one-hot values are eligible for capture.
- seg  in  7  segment levels, active-high; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- hex_out  out  16  captured digits; nibble i = digit i (hex_out[4i+3:4i]).
- digit_valid  out  4  bit i set when digit i's last capture was a recognised pattern.
- bad_pattern  out  4  bit i set when digit i's last capture was unrecognised.
- frame_done  out  1  one-cycle pulse after all four digits captured since previous pulse/reset.

## Operation
- Recognised patterns (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. All other 112 patterns are bad.
- Held sample {held_sel, held_seg} and saturating counter cnt (8 bits).
- State machine (2-bit): IDLE, TRACK, HOLD.
  - IDLE: held_sel not one-hot. Any edge where input differs from held: load held, cnt<=1, go TRACK if new dig_sel one-hot else stay IDLE.
  - TRACK: input equal to held: cnt<=cnt+1; if cnt==STABLE_CYCLES-1, capture this edge and go HOLD. Input differs: load held, cnt<=1, TRACK or IDLE per one-hotness.
  - HOLD: input equal: no action (no recapture). Input differs: as TRACK mismatch.
- Capture of digit i (i = index of held_sel bit): recognised -> nibble i <= decoded value, digit_valid[i]<=1, bad_pattern[i]<=0; unrecognised -> nibble i unchanged, digit_valid[i]<=0, bad_pattern[i]<=1.
- Frame tracking: 4-bit seen mask. On capture: if (seen | bit i)==4'hF then seen<=0, frame_done<=1; else seen<=seen|bit i. frame_done<=0 on every other edge. Recapturing an already-seen digit does not complete a frame.
- dig_sel==0 or multi-hot: never captured; treated as a distinct value (breaks stability of previous digit).

## Timing
- Reset: hex_out=0, digit_valid=0, bad_pattern=0, frame_done=0, seen=0, held=0, cnt=0, state IDLE.
- Input first sampled at edge k and held constant: capture at edge k+STABLE_CYCLES-1; outputs visible after that edge. Any change inside the window restarts the count from the changing edge.
- frame_done high exactly one cycle, the cycle after the completing capture edge.
- Reset mid-window discards tracking; an unchanged input after reset deasserts needs a full STABLE_CYCLES window (first sample edge differs from held=0 unless dig_sel=0).
- Reset has priority over capture on the same edge.
- No combinational path from inputs to outputs.

## Structure
- Package seg7_pkg: 16 pattern constants, segment bit-index constants, default STABLE_CYCLES, state enum.
- Sub-module seg7_pattern_decode: combinational seg[6:0] -> {hit, value[3:0]}; reused by other display checkers.
- Top holds held sample, counter, FSM, per-digit registers, seen mask.

## Test plan
- STABLE_CYCLES=4, dig_sel=0001, seg=7'h5B held 4 edges -> after 4th edge hex_out[3:0]=2, digit_valid=0001; after 3rd edge still 0.
- Scan 0001:06, 0010:4F, 0100:66, 1000:71, 5 cycles each -> hex_out=16'hF431, frame_done one-cycle pulse after 4th capture, seen cleared.
- dig_sel=0010, seg toggles 3F/06 every 2 cycles -> no capture, hex_out unchanged, digit_valid[1]=0.
- dig_sel=0100, seg=7'h01 held 6 cycles -> bad_pattern=0100, digit_valid[2]=0, nibble 2 unchanged; only one capture.
- dig_sel=0011 and 0000 held 10 cycles -> no output change, frame_done never asserted.
- Reset asserted at 3rd cycle of a 4-cycle window, same input held -> capture occurs 4 edges after reset deasserts, not earlier.
